mem_access_unit: RTL and testbench

- Parametrised successor to the pipeline MEM stage datapath.
- Owns the dcache request/response handshake through a sequencing FSM.
- Supports word and byte accesses with lane steering, and two-phase indirect (LDI/STI) accesses.
- Produces a registered read result and a completion pulse for the WB latch; asserts mem_stall to freeze upstream stages.

---
 rtl/mem_access_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data access sequencer.
//
// Owns the dcache request/response handshake for loads and stores. Word and byte
// accesses are lane-steered onto the cache bus. Indirect accesses (LDI/STI)
// first fetch a pointer word and then run the data access at that pointer. Load
// data is returned in a register. A one-cycle done pulse marks a completed access.
//
// Parameters:
//   DATA_WIDTH  data word width, a power-of-two multiple of 8 and at least 16
//   ADDR_WIDTH  address width
//   NBYTES      byte lanes per word (derived)
//   LSB_W       byte-offset address bits (derived)
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   valid_in             MEM-stage op valid
//   mem_read_in          op is a load
//   mem_write_in         op is a store
//   byte_in              byte access (0: word access)
//   indirect_in          two-phase pointer access
//   address_in           effective address
//   wdata_in             store data; the byte for byte stores is in [7:0]
//   dcache_rdata         cache read data
//   dcache_resp          cache completion strobe
//   dcache_address       request address
//   dcache_read          read request
//   dcache_write         write request
//   dcache_wdata         lane-steered store data
//   dcache_byte_enable   per-lane enables
//   mem_stall            freezes upstream stages
//   done                 one-cycle completion pulse
//   rdata_out            registered load result
//   misalign             (MEM_ACCESS_MISALIGN_TRAP_EN only) misaligned-access trap,
//                        pulses with done
//
// Build option:
//   MEM_ACCESS_MISALIGN_TRAP_EN  When this is defined, a word access or pointer fetch
//                                whose address has nonzero byte-offset bits issues no
//                                cache request and traps instead. When it is undefined,
//                                the offset bits are cleared.

module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic                    mem_read_in,
    input  logic                    mem_write_in,
    input  logic                    byte_in,
    input  logic                    indirect_in,
    input  logic [ADDR_WIDTH-1:0]   address_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic [DATA_WIDTH-1:0]   dcache_rdata,
    input  logic                    dcache_resp,
    output logic [ADDR_WIDTH-1:0]   dcache_address,
    output logic                    dcache_read,
    output logic                    dcache_write,
    output logic [DATA_WIDTH-1:0]   dcache_wdata,
    output logic [DATA_WIDTH/8-1:0] dcache_byte_enable,
    output logic                    mem_stall,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rdata_out
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ,
    output logic                    misalign
`endif
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB_W  = $clog2(NBYTES);

    typedef enum logic [1:0] {
        StIdle,
        StPtr,
        StData
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  byte_q, byte_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic [LSB_W-1:0]      lane;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic [NBYTES-1:0]     be_byte;
    logic [7:0]            rd_byte;

    assign accept       = valid_in & (mem_read_in | mem_write_in);
    assign lane         = addr_q[LSB_W-1:0];
    assign addr_aligned = {addr_q[ADDR_WIDTH-1:LSB_W], {LSB_W{1'b0}}};
    assign be_byte      = {{(NBYTES-1){1'b0}}, 1'b1} << lane;
    assign rd_byte      = dcache_rdata[8*lane +: 8];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic acc_misaligned;
    logic ptr_misaligned;

    // An indirect op always starts with a word-sized pointer fetch.
    assign acc_misaligned = (indirect_in | ~byte_in) & (|address_in[LSB_W-1:0]);
    // A word access through a freshly fetched pointer that is not aligned.
    assign ptr_misaligned = ~byte_q & (|dcache_rdata[LSB_W-1:0]);
    assign misalign       = misalign_q;
`endif

    // Requests depend only on the state and the captured registers. They stay
    // stable while the cache is busy, even when the upstream inputs change.
    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        byte_d             = byte_q;
        write_d            = write_q;
        rdata_d            = rdata_q;
        done_d             = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign_d         = 1'b0;
`endif
        dcache_address     = '0;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_wdata       = '0;
        dcache_byte_enable = '0;
        mem_stall          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d    = address_in;
                    wdata_d   = wdata_in;
                    byte_d    = byte_in;
                    write_d   = mem_write_in;
                    mem_stall = 1'b1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    if (acc_misaligned) begin
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else
`endif
                    begin
                        state_d = indirect_in ? StPtr : StData;
                    end
                end
            end

            StPtr: begin
                dcache_read        = 1'b1;
                dcache_address     = addr_aligned;
                dcache_byte_enable = '1;
                mem_stall          = 1'b1;
                if (dcache_resp) begin
                    addr_d = ADDR_WIDTH'(dcache_rdata);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    if (ptr_misaligned) begin
                        state_d    = StIdle;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else
`endif
                    begin
                        state_d = StData;
                    end
                end
            end

            StData: begin
                dcache_read  = ~write_q;
                dcache_write = write_q;
                mem_stall    = ~dcache_resp;
                if (byte_q) begin
                    dcache_address     = addr_q;
                    dcache_byte_enable = be_byte;
                    dcache_wdata       = {NBYTES{wdata_q[7:0]}};
                end else begin
                    dcache_address     = addr_aligned;
                    dcache_byte_enable = '1;
                    dcache_wdata       = wdata_q;
                end
                if (dcache_resp) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (!write_q) begin
                        rdata_d = byte_q ? DATA_WIDTH'(rd_byte) : dcache_rdata;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_q     <= 1'b0;
            write_q    <= 1'b0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            byte_q     <= byte_d;
            write_q    <= write_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign done      = done_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It runs the default 16-bit build, plus a 32-bit
// instance that covers the wide lane steering.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, mem_read_in, mem_write_in, byte_in, indirect_in;
    logic [15:0] address_in, wdata_in, dcache_rdata;
    logic        dcache_resp;
    logic [15:0] dcache_address, dcache_wdata, rdata_out;
    logic        dcache_read, dcache_write, mem_stall, done;
    logic [1:0]  dcache_byte_enable;

    logic        w_valid, w_rd, w_wr, w_byte, w_ind, w_resp;
    logic [15:0] w_addr, w_daddr;
    logic [31:0] w_wdata, w_crdata, w_dwdata, w_rdata_out;
    logic        w_dread, w_dwrite, w_stall, w_done;
    logic [3:0]  w_be;

    int total = 0;
    int bad   = 0;

    // Scoreboards: expected rdata_out at each done pulse.
    logic [15:0] sb[$];
    logic [31:0] sbw[$];
    logic [15:0] last_rd;
    logic [15:0] exp_rd;
    logic [31:0] exp_w;

    // Observations recorded by run_access.
    int          obs_stall;
    logic        obs_unstable, obs_early_req, obs_early_done;
    logic [15:0] obs_ptr_addr, obs_addr, obs_wdata, obs_rdata;
    logic [1:0]  obs_ptr_be, obs_be;
    logic        obs_ptr_rd, obs_ptr_wr, obs_rd, obs_wr;
    logic        obs_done, obs_tail_req, obs_tail_stall;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk                (clk),
        .reset              (reset),
        .valid_in           (valid_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .byte_in            (byte_in),
        .indirect_in        (indirect_in),
        .address_in         (address_in),
        .wdata_in           (wdata_in),
        .dcache_rdata       (dcache_rdata),
        .dcache_resp        (dcache_resp),
        .dcache_address     (dcache_address),
        .dcache_read        (dcache_read),
        .dcache_write       (dcache_write),
        .dcache_wdata       (dcache_wdata),
        .dcache_byte_enable (dcache_byte_enable),
        .mem_stall          (mem_stall),
        .done               (done),
        .rdata_out          (rdata_out)
    );

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut_w (
        .clk                (clk),
        .reset              (reset),
        .valid_in           (w_valid),
        .mem_read_in        (w_rd),
        .mem_write_in       (w_wr),
        .byte_in            (w_byte),
        .indirect_in        (w_ind),
        .address_in         (w_addr),
        .wdata_in           (w_wdata),
        .dcache_rdata       (w_crdata),
        .dcache_resp        (w_resp),
        .dcache_address     (w_daddr),
        .dcache_read        (w_dread),
        .dcache_write       (w_dwrite),
        .dcache_wdata       (w_dwdata),
        .dcache_byte_enable (w_be),
        .mem_stall          (w_stall),
        .done               (w_done),
        .rdata_out          (w_rdata_out)
    );

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one access. The accept cycle is the current cycle. The cache answers
    // the pointer fetch after lat1 idle cycles and the data access after lat2 idle
    // cycles. The task returns in the done cycle, after it has sampled it.
    task automatic run_access(input logic rd, input logic wr, input logic byt, input logic ind,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input logic [15:0] ptr_word, input int lat1,
                              input logic [15:0] data_word, input int lat2);
        obs_stall = 0; obs_unstable = 1'b0; obs_early_req = 1'b0; obs_early_done = 1'b0;
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; byte_in = byt;
        indirect_in = ind; address_in = addr; wdata_in = wd; dcache_resp = 1'b0;
        #1;
        if (mem_stall) obs_stall++;
        if (dcache_read || dcache_write) obs_early_req = 1'b1;
        next_cycle();
        // Scramble the upstream inputs so that the DUT must use its captured copies.
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; byte_in = 1'b0;
        indirect_in = 1'b0; address_in = ~addr; wdata_in = ~wd;
        if (ind) begin
            for (int i = 0; i <= lat1; i++) begin
                if (i > 0) next_cycle();
                dcache_resp  = (i == lat1);
                dcache_rdata = (i == lat1) ? ptr_word : 16'hDEAD;
                #1;
                if (mem_stall) obs_stall++;
                if (done) obs_early_done = 1'b1;
                if (i == 0) begin
                    obs_ptr_addr = dcache_address; obs_ptr_be = dcache_byte_enable;
                    obs_ptr_rd = dcache_read; obs_ptr_wr = dcache_write;
                end else if (dcache_address !== obs_ptr_addr || dcache_read !== obs_ptr_rd ||
                             dcache_byte_enable !== obs_ptr_be) begin
                    obs_unstable = 1'b1;
                end
            end
            next_cycle();
        end
        for (int i = 0; i <= lat2; i++) begin
            if (i > 0) next_cycle();
            dcache_resp  = (i == lat2);
            dcache_rdata = (i == lat2) ? data_word : 16'hDEAD;
            #1;
            if (mem_stall) obs_stall++;
            if (done) obs_early_done = 1'b1;
            if (i == 0) begin
                obs_addr = dcache_address; obs_be = dcache_byte_enable; obs_wdata = dcache_wdata;
                obs_rd = dcache_read; obs_wr = dcache_write;
            end else if (dcache_address !== obs_addr || dcache_byte_enable !== obs_be ||
                         dcache_wdata !== obs_wdata || dcache_read !== obs_rd ||
                         dcache_write !== obs_wr) begin
                obs_unstable = 1'b1;
            end
        end
        next_cycle();
        dcache_resp = 1'b0; dcache_rdata = 16'hDEAD;
        #1;
        obs_done = done; obs_rdata = rdata_out; obs_tail_stall = mem_stall;
        obs_tail_req = dcache_read | dcache_write;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++; if ({dcache_read, dcache_write, mem_stall, done} !== 4'b0000) begin bad++;
            $display("FAIL reset_ctrl got=%b want=0000", {dcache_read, dcache_write, mem_stall, done}); end
        total++; if (rdata_out !== 16'h0000) begin bad++;
            $display("FAIL reset_rdata got=%h want=0000", rdata_out); end
        total++; if (dcache_address !== 16'h0000 || dcache_byte_enable !== 2'b00) begin bad++;
            $display("FAIL reset_req got=%h/%b want=0000/00", dcache_address, dcache_byte_enable); end
        reset = 1'b0;
        next_cycle();
        #1;
        total++; if ({dcache_read, mem_stall, done} !== 3'b000) begin bad++;
            $display("FAIL post_reset_idle got=%b want=000", {dcache_read, mem_stall, done}); end
        last_rd = 16'h0000;
    endtask

    task automatic test_word_load();
        sb.push_back(16'hBEEF); last_rd = 16'hBEEF;
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0, 16'hBEEF, 3);
        total++; if (obs_addr !== 16'h1234 || obs_be !== 2'b11) begin bad++;
            $display("FAIL word_load_req got=%h/%b want=1234/11", obs_addr, obs_be); end
        total++; if (obs_rd !== 1'b1 || obs_wr !== 1'b0) begin bad++;
            $display("FAIL word_load_type got=rd%b wr%b want=rd1 wr0", obs_rd, obs_wr); end
        total++; if (obs_stall != 4) begin bad++;
            $display("FAIL word_load_stall got=%0d want=4", obs_stall); end
        total++; if (obs_unstable !== 1'b0 || obs_early_req !== 1'b0 || obs_early_done !== 1'b0) begin bad++;
            $display("FAIL word_load_hold got=%b%b%b want=000", obs_unstable, obs_early_req, obs_early_done); end
        total++; if (obs_tail_req !== 1'b0 || obs_tail_stall !== 1'b0) begin bad++;
            $display("FAIL word_load_tail got=%b%b want=00", obs_tail_req, obs_tail_stall); end
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL word_load_rdata got=done%b %h want=done1 %h", obs_done, obs_rdata, exp_rd); end
        next_cycle();
        #1;
        total++; if (done !== 1'b0) begin bad++;
            $display("FAIL word_load_pulse got=%b want=0", done); end
    endtask

    task automatic test_byte_access();
        sb.push_back(16'h00A5); last_rd = 16'h00A5;
        run_access(1'b1, 1'b0, 1'b1, 1'b0, 16'h1235, 16'h0000, 16'h0000, 0, 16'hA55A, 1);
        total++; if (obs_addr !== 16'h1235 || obs_be !== 2'b10) begin bad++;
            $display("FAIL byte_load_req got=%h/%b want=1235/10", obs_addr, obs_be); end
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL byte_load_rdata got=done%b %h want=done1 %h", obs_done, obs_rdata, exp_rd); end
        next_cycle();
        // Byte store: only bits [7:0] of the store data count.
        sb.push_back(last_rd);
        run_access(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'hAB77, 16'h0000, 0, 16'h0000, 2);
        total++; if (obs_wdata !== 16'h7777 || obs_be !== 2'b01 || obs_addr !== 16'h1234) begin bad++;
            $display("FAIL byte_store_req got=%h/%b/%h want=7777/01/1234", obs_wdata, obs_be, obs_addr); end
        total++; if (obs_wr !== 1'b1 || obs_rd !== 1'b0 || obs_unstable !== 1'b0) begin bad++;
            $display("FAIL byte_store_type got=wr%b rd%b u%b want=wr1 rd0 u0", obs_wr, obs_rd, obs_unstable); end
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL byte_store_hold got=done%b %h want=done1 %h", obs_done, obs_rdata, exp_rd); end
        next_cycle();
        // A misaligned word store has its offset bits cleared.
        sb.push_back(last_rd);
        run_access(1'b0, 1'b1, 1'b0, 1'b0, 16'h1237, 16'hCAFE, 16'h0000, 0, 16'h0000, 0);
        total++; if (obs_wdata !== 16'hCAFE || obs_be !== 2'b11 || obs_addr !== 16'h1236) begin bad++;
            $display("FAIL word_store_req got=%h/%b/%h want=cafe/11/1236", obs_wdata, obs_be, obs_addr); end
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL word_store_hold got=done%b %h want=done1 %h", obs_done, obs_rdata, exp_rd); end
        next_cycle();
        sb.push_back(16'h005A); last_rd = 16'h005A;
        run_access(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0, 16'hA55A, 0);
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd || obs_be !== 2'b01) begin bad++;
            $display("FAIL byte_load_lane0 got=done%b %h/%b want=done1 %h/01", obs_done, obs_rdata, obs_be, exp_rd); end
        next_cycle();
    endtask

    task automatic test_indirect();
        sb.push_back(16'h0042); last_rd = 16'h0042;
        run_access(1'b1, 1'b0, 1'b0, 1'b1, 16'h2000, 16'h0000, 16'h3000, 1, 16'h0042, 2);
        total++; if (obs_ptr_addr !== 16'h2000 || obs_ptr_be !== 2'b11 || obs_ptr_rd !== 1'b1 || obs_ptr_wr !== 1'b0) begin bad++;
            $display("FAIL ldi_ptr_req got=%h/%b rd%b wr%b want=2000/11 rd1 wr0", obs_ptr_addr, obs_ptr_be, obs_ptr_rd, obs_ptr_wr); end
        total++; if (obs_addr !== 16'h3000 || obs_rd !== 1'b1) begin bad++;
            $display("FAIL ldi_data_req got=%h rd%b want=3000 rd1", obs_addr, obs_rd); end
        total++; if (obs_stall != 5 || obs_early_done !== 1'b0) begin bad++;
            $display("FAIL ldi_stall got=%0d ed%b want=5 ed0", obs_stall, obs_early_done); end
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL ldi_rdata got=done%b %h want=done1 %h", obs_done, obs_rdata, exp_rd); end
        next_cycle();
        // Byte STI: the pointer fetch is word-wide, and the data phase is a byte at the pointer.
        sb.push_back(last_rd);
        run_access(1'b0, 1'b1, 1'b1, 1'b1, 16'h2002, 16'h119C, 16'h4001, 0, 16'h0000, 0);
        total++; if (obs_ptr_addr !== 16'h2002 || obs_ptr_rd !== 1'b1 || obs_ptr_be !== 2'b11) begin bad++;
            $display("FAIL sti_ptr_req got=%h rd%b %b want=2002 rd1 11", obs_ptr_addr, obs_ptr_rd, obs_ptr_be); end
        total++; if (obs_addr !== 16'h4001 || obs_be !== 2'b10 || obs_wdata !== 16'h9C9C || obs_wr !== 1'b1) begin bad++;
            $display("FAIL sti_data_req got=%h/%b/%h wr%b want=4001/10/9c9c wr1", obs_addr, obs_be, obs_wdata, obs_wr); end
        total++; if (obs_stall != 2) begin bad++;
            $display("FAIL sti_stall got=%0d want=2", obs_stall); end
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL sti_hold got=done%b %h want=done1 %h", obs_done, obs_rdata, exp_rd); end
        next_cycle();
    endtask

    task automatic test_idle_ignore();
        valid_in = 1'b0; mem_read_in = 1'b1; address_in = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            total++; if ({dcache_read, dcache_write, mem_stall, done} !== 4'b0000) begin bad++;
                $display("FAIL invalid_op got=%b want=0000", {dcache_read, dcache_write, mem_stall, done}); end
        end
        mem_read_in = 1'b0;
        dcache_resp = 1'b1; dcache_rdata = 16'hFFFF;
        next_cycle();
        dcache_resp = 1'b0;
        #1;
        total++; if (rdata_out !== last_rd || done !== 1'b0 || dcache_read !== 1'b0) begin bad++;
            $display("FAIL spurious_resp got=%h d%b r%b want=%h d0 r0", rdata_out, done, dcache_read, last_rd); end
        sb.push_back(16'h0F0F); last_rd = 16'h0F0F;
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 0, 16'h0F0F, 1);
        exp_rd = sb.pop_front();
        total++; if (obs_addr !== 16'h0100 || obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL after_spurious got=%h done%b %h want=0100 done1 %h", obs_addr, obs_done, obs_rdata, exp_rd); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        valid_in = 1'b1; mem_read_in = 1'b1; address_in = 16'h1100;
        next_cycle();
        valid_in = 1'b0; mem_read_in = 1'b0;
        #1;
        total++; if (dcache_read !== 1'b1 || mem_stall !== 1'b1) begin bad++;
            $display("FAIL mid_reset_pre got=r%b s%b want=r1 s1", dcache_read, mem_stall); end
        next_cycle();
        reset = 1'b1;
        #1;
        total++; if ({dcache_read, dcache_write, mem_stall, done} !== 4'b0000 || dcache_address !== 16'h0000) begin bad++;
            $display("FAIL mid_reset_drop got=%b %h want=0000 0000", {dcache_read, dcache_write, mem_stall, done}, dcache_address); end
        next_cycle();
        reset = 1'b0;
        next_cycle();
        #1;
        total++; if (dcache_read !== 1'b0 || mem_stall !== 1'b0 || rdata_out !== 16'h0000) begin bad++;
            $display("FAIL mid_reset_idle got=r%b s%b %h want=r0 s0 0000", dcache_read, mem_stall, rdata_out); end
        sb.push_back(16'h5555); last_rd = 16'h5555;
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h1102, 16'h0000, 16'h0000, 0, 16'h5555, 1);
        exp_rd = sb.pop_front();
        total++; if (obs_addr !== 16'h1102 || obs_stall != 2 || obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL mid_reset_next got=%h st%0d done%b %h want=1102 st2 done1 %h", obs_addr, obs_stall, obs_done, obs_rdata, exp_rd); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        sb.push_back(16'h1111);
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 0, 16'h1111, 0);
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd || obs_stall != 1) begin bad++;
            $display("FAIL b2b_first got=done%b %h st%0d want=done1 %h st1", obs_done, obs_rdata, obs_stall, exp_rd); end
        total++; if (obs_tail_req !== 1'b0) begin bad++;
            $display("FAIL b2b_bubble got=%b want=0", obs_tail_req); end
        // The next op is accepted in the done cycle of the previous one.
        sb.push_back(16'h0022); last_rd = 16'h0022;
        run_access(1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 16'h0000, 0, 16'h2222, 1);
        total++; if (obs_addr !== 16'h0021 || obs_be !== 2'b10 || obs_stall != 2) begin bad++;
            $display("FAIL b2b_second_req got=%h/%b st%0d want=0021/10 st2", obs_addr, obs_be, obs_stall); end
        exp_rd = sb.pop_front();
        total++; if (obs_done !== 1'b1 || obs_rdata !== exp_rd) begin bad++;
            $display("FAIL b2b_second_rdata got=done%b %h want=done1 %h", obs_done, obs_rdata, exp_rd); end
        next_cycle();
    endtask

    task automatic test_wide_bytes();
        sbw.push_back(32'h0000_0000);
        w_valid = 1'b1; w_wr = 1'b1; w_byte = 1'b1; w_addr = 16'h0007; w_wdata = 32'h1234_56A5;
        next_cycle();
        w_valid = 1'b0; w_wr = 1'b0; w_byte = 1'b0; w_addr = 16'h0000; w_wdata = '0; w_resp = 1'b1;
        #1;
        total++; if (w_be !== 4'b1000 || w_dwdata !== 32'hA5A5_A5A5 || w_daddr !== 16'h0007 || w_dwrite !== 1'b1) begin bad++;
            $display("FAIL wide_stb_req got=%b/%h/%h wr%b want=1000/a5a5a5a5/0007 wr1", w_be, w_dwdata, w_daddr, w_dwrite); end
        next_cycle();
        w_resp = 1'b0;
        #1;
        exp_w = sbw.pop_front();
        total++; if (w_done !== 1'b1 || w_rdata_out !== exp_w) begin bad++;
            $display("FAIL wide_stb_done got=done%b %h want=done1 %h", w_done, w_rdata_out, exp_w); end
        next_cycle();
        sbw.push_back(32'h0000_0011);
        w_valid = 1'b1; w_rd = 1'b1; w_byte = 1'b1; w_addr = 16'h0003;
        next_cycle();
        w_valid = 1'b0; w_rd = 1'b0; w_byte = 1'b0; w_resp = 1'b1; w_crdata = 32'h1122_3344;
        #1;
        total++; if (w_be !== 4'b1000 || w_dread !== 1'b1) begin bad++;
            $display("FAIL wide_ldb_req got=%b rd%b want=1000 rd1", w_be, w_dread); end
        next_cycle();
        w_resp = 1'b0;
        #1;
        exp_w = sbw.pop_front();
        total++; if (w_done !== 1'b1 || w_rdata_out !== exp_w) begin bad++;
            $display("FAIL wide_ldb_rdata got=done%b %h want=done1 %h", w_done, w_rdata_out, exp_w); end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; byte_in = 1'b0;
        indirect_in = 1'b0; address_in = '0; wdata_in = '0; dcache_rdata = '0; dcache_resp = 1'b0;
        w_valid = 1'b0; w_rd = 1'b0; w_wr = 1'b0; w_byte = 1'b0; w_ind = 1'b0;
        w_addr = '0; w_wdata = '0; w_crdata = '0; w_resp = 1'b0;
        last_rd = '0;
        test_reset();
        test_word_load();
        test_byte_access();
        test_indirect();
        test_idle_ignore();
        test_reset_mid();
        test_back_to_back();
        test_wide_bytes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
